// File: rtl/bus_arbiter_2m.sv
// Two-master / five-slave bus arbiter and router: grants the bus, routes master signals, decodes slave select, returns read data.
// Optional feature: define BUS_ARB_TIMEOUT_EN to bound how long M1 may hold the bus while M0 is waiting.
module bus_arbiter_2m #(
    parameter int ADDR_W   = 16,
    parameter int DATA_W   = 32,
    parameter int MAX_HOLD = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              m0_req,
    input  logic              m0_wr,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_dout,
    input  logic              m1_req,
    input  logic              m1_wr,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_dout,
    output logic              m0_grant,
    output logic              m1_grant,
    output logic              s_wr,
    output logic [ADDR_W-1:0] s_addr,
    output logic [DATA_W-1:0] s_dout,
    output logic [4:0]        s_sel,
    input  logic [DATA_W-1:0] s0_din,
    input  logic [DATA_W-1:0] s1_din,
    input  logic [DATA_W-1:0] s2_din,
    input  logic [DATA_W-1:0] s3_din,
    input  logic [DATA_W-1:0] s4_din,
    output logic [DATA_W-1:0] m_din
);

    typedef enum logic {GNT_M0 = 1'b0, GNT_M1 = 1'b1} state_t;

    state_t     state;
    logic [4:0] sel_q;
    logic       bus_active;
    logic       bus_wr;
    logic [4:0] dec_sel;
    logic       hold_expired;

    // M0 is the default owner and always drives the bus; M1 only drives while it requests
    always_comb begin
        bus_active = 1'b1;
        bus_wr     = m0_wr;
        s_addr     = m0_addr;
        s_dout     = m0_dout;
        if (state == GNT_M1) begin
            bus_active = m1_req;
            bus_wr     = m1_wr & m1_req;
            s_addr     = m1_addr;
            s_dout     = m1_dout;
        end
        dec_sel = 5'b00000;
        if (bus_active) begin
            case (s_addr[15:8])
                8'h00:   dec_sel = 5'b00001;
                8'h01:   dec_sel = 5'b00010;
                8'h02:   dec_sel = 5'b00100;
                8'h03:   dec_sel = 5'b01000;
                8'h04:   dec_sel = 5'b10000;
                default: dec_sel = 5'b00000;
            endcase
        end
        s_sel = dec_sel;
        s_wr  = bus_wr & (|dec_sel);
    end

`ifdef BUS_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(MAX_HOLD + 1);

    logic [CNT_W-1:0] hold_cnt;

    assign hold_expired = (state == GNT_M1) && m0_req && (hold_cnt == CNT_W'(MAX_HOLD - 1));

    // Counts consecutive M1-owned cycles with M0 waiting; M0 cannot lose the bus again until it drops m0_req
    always_ff @(posedge clk) begin
        if (reset || state != GNT_M1 || !m0_req || hold_expired)
            hold_cnt <= '0;
        else
            hold_cnt <= hold_cnt + 1'b1;
    end
`else
    assign hold_expired = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= GNT_M0;
            m0_grant <= 1'b1;
            m1_grant <= 1'b0;
        end else if (state == GNT_M0) begin
            if (m1_req && !m0_req) begin
                state    <= GNT_M1;
                m0_grant <= 1'b0;
                m1_grant <= 1'b1;
            end
        end else begin
            if (!m1_req || hold_expired) begin
                state    <= GNT_M0;
                m0_grant <= 1'b1;
                m1_grant <= 1'b0;
            end
        end
    end

    // Slaves answer one cycle after the address, so the registered select steers the returning data
    always_ff @(posedge clk) begin
        if (reset)
            sel_q <= 5'b00000;
        else
            sel_q <= s_sel & {5{~s_wr}};
    end

    always_comb begin
        m_din = ({DATA_W{sel_q[0]}} & s0_din)
              | ({DATA_W{sel_q[1]}} & s1_din)
              | ({DATA_W{sel_q[2]}} & s2_din)
              | ({DATA_W{sel_q[3]}} & s3_din)
              | ({DATA_W{sel_q[4]}} & s4_din);
    end

endmodule

// File: tb/tb_bus_arbiter_2m.sv
// Self-checking bench for bus_arbiter_2m: directed literal checks plus randomized traffic against a behavioural model.
module tb_bus_arbiter_2m;

    localparam int ADDR_W   = 16;
    localparam int DATA_W   = 32;
    localparam int MAX_HOLD = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              m0_req, m0_wr, m1_req, m1_wr;
    logic [ADDR_W-1:0] m0_addr, m1_addr;
    logic [DATA_W-1:0] m0_dout, m1_dout;
    logic              m0_grant, m1_grant, s_wr;
    logic [ADDR_W-1:0] s_addr;
    logic [DATA_W-1:0] s_dout, m_din;
    logic [4:0]        s_sel;
    logic [DATA_W-1:0] s0_din, s1_din, s2_din, s3_din, s4_din;

    int n_checks = 0;
    int n_fail   = 0;

    // Model state: who owns the bus, which slave (if any) was read last cycle, cycles M1 held with M0 waiting
    int owner       = 0;
    int prev_read   = -1;
    int held        = 0;
    bit model_valid = 1'b0;

    bus_arbiter_2m #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_HOLD(MAX_HOLD)) dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_wr(m0_wr), .m0_addr(m0_addr), .m0_dout(m0_dout),
        .m1_req(m1_req), .m1_wr(m1_wr), .m1_addr(m1_addr), .m1_dout(m1_dout),
        .m0_grant(m0_grant), .m1_grant(m1_grant),
        .s_wr(s_wr), .s_addr(s_addr), .s_dout(s_dout), .s_sel(s_sel),
        .s0_din(s0_din), .s1_din(s1_din), .s2_din(s2_din), .s3_din(s3_din), .s4_din(s4_din),
        .m_din(m_din)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input bit rst, input bit r0, input bit w0, input logic [15:0] a0,
                                 input logic [31:0] d0, input bit r1, input bit w1,
                                 input logic [15:0] a1, input logic [31:0] d1);
        reset = rst; m0_req = r0; m0_wr = w0; m0_addr = a0; m0_dout = d0;
        m1_req = r1; m1_wr = w1; m1_addr = a1; m1_dout = d1;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Slave index addressed this cycle by the current owner, or -1 when nothing is selected
    function automatic int target_slave();
        logic [15:0] a;
        if (owner == 1 && !m1_req) return -1;
        a = (owner == 1) ? m1_addr : m0_addr;
        if (a[15:8] < 8'd5) return int'(a[15:8]);
        return -1;
    endfunction

    function automatic bit target_write();
        if (target_slave() < 0) return 1'b0;
        return (owner == 1) ? m1_wr : m0_wr;
    endfunction

    function automatic logic [31:0] slave_data(input int idx);
        case (idx)
            0: return s0_din;
            1: return s1_din;
            2: return s2_din;
            3: return s3_din;
            4: return s4_din;
            default: return 32'h0;
        endcase
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            owner       = 0;
            prev_read   = -1;
            held        = 0;
            model_valid = 1'b1;
        end else begin
            prev_read = (target_slave() >= 0 && !target_write()) ? target_slave() : -1;
            if (owner == 0) begin
                held = 0;
                if (m1_req && !m0_req) owner = 1;
            end else if (!m1_req) begin
                owner = 0;
                held  = 0;
            end else if (m0_req) begin
                held++;
`ifdef BUS_ARB_TIMEOUT_EN
                if (held >= MAX_HOLD) begin
                    owner = 0;
                    held  = 0;
                end
`endif
            end else begin
                held = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (model_valid) begin
            int t;
            t = target_slave();
            checkOutput("m0_grant", 32'(m0_grant), 32'(owner == 0));
            checkOutput("m1_grant", 32'(m1_grant), 32'(owner == 1));
            checkOutput("s_sel", 32'(s_sel), (t >= 0) ? (32'd1 << t) : 32'd0);
            checkOutput("s_wr", 32'(s_wr), 32'(target_write()));
            checkOutput("s_addr", 32'(s_addr), 32'((owner == 1) ? m1_addr : m0_addr));
            checkOutput("s_dout", s_dout, (owner == 1) ? m1_dout : m0_dout);
            checkOutput("m_din", m_din, slave_data(prev_read));
        end
    end

    initial begin
        s0_din = 32'h0; s1_din = 32'h0; s2_din = 32'h0; s3_din = 32'h0; s4_din = 32'h0;
        applyStimulus(1, 0, 0, 16'hff00, 0, 0, 0, 16'h0000, 0);
        next_cycle();
        next_cycle();
        @(negedge clk);
        checkOutput("rst_m0_grant", 32'(m0_grant), 32'd1);
        checkOutput("rst_m1_grant", 32'(m1_grant), 32'd0);
        checkOutput("rst_s_sel", 32'(s_sel), 32'd0);
        checkOutput("rst_m_din", m_din, 32'd0);

        next_cycle();
        applyStimulus(0, 1, 1, 16'h0302, 32'h256a, 0, 0, 16'h0000, 0);
        @(negedge clk);
        checkOutput("m0_wr_sel", 32'(s_sel), 32'b01000);
        checkOutput("m0_wr_strobe", 32'(s_wr), 32'd1);
        checkOutput("m0_wr_data", s_dout, 32'h0000_256a);

        next_cycle();
        applyStimulus(0, 0, 0, 16'h0000, 0, 1, 1, 16'h0103, 32'h55);
        @(negedge clk);
        checkOutput("m1_req_grant_late", 32'(m1_grant), 32'd0);
        next_cycle();
        @(negedge clk);
        checkOutput("m1_granted", 32'(m1_grant), 32'd1);
        checkOutput("m1_wr_sel", 32'(s_sel), 32'b00010);
        checkOutput("m1_wr_strobe", 32'(s_wr), 32'd1);
        next_cycle();
        applyStimulus(0, 1, 0, 16'h0000, 0, 1, 1, 16'h0103, 32'h55);
        next_cycle();
        @(negedge clk);
        checkOutput("m1_no_preempt", 32'(m1_grant), 32'd1);
        next_cycle();
        applyStimulus(0, 1, 0, 16'h0000, 0, 0, 1, 16'h0103, 32'h55);
        @(negedge clk);
        checkOutput("m1_idle_sel", 32'(s_sel), 32'd0);
        next_cycle();
        @(negedge clk);
        checkOutput("m0_regrant", 32'(m0_grant), 32'd1);

        next_cycle();
        s1_din = 32'h10;
        applyStimulus(0, 1, 0, 16'h0110, 0, 0, 0, 16'h0000, 0);
        next_cycle();
        applyStimulus(0, 1, 0, 16'h0600, 0, 0, 0, 16'h0000, 0);
        @(negedge clk);
        checkOutput("rd_data", m_din, 32'h10);
        checkOutput("unmapped_sel", 32'(s_sel), 32'd0);
        next_cycle();
        @(negedge clk);
        checkOutput("unmapped_rd", m_din, 32'd0);

        next_cycle();
        s4_din = 32'habcd;
        applyStimulus(0, 0, 0, 16'h0000, 0, 1, 0, 16'h0405, 0);
        next_cycle();
        @(negedge clk);
        checkOutput("m1_rd_sel", 32'(s_sel), 32'b10000);
        reset = 1'b1;
        next_cycle();
        @(negedge clk);
        checkOutput("midrst_m0_grant", 32'(m0_grant), 32'd1);
        checkOutput("midrst_m1_grant", 32'(m1_grant), 32'd0);
        checkOutput("midrst_m_din", m_din, 32'd0);

        for (int i = 0; i < 3000; i++) begin
            next_cycle();
            applyStimulus(($urandom_range(63) == 0),
                          ($urandom_range(2) != 0), $urandom_range(1),
                          {8'($urandom_range(6)), 8'($urandom)}, $urandom,
                          ($urandom_range(3) != 0), $urandom_range(1),
                          {8'($urandom_range(6)), 8'($urandom)}, $urandom);
            s0_din = $urandom; s1_din = $urandom; s2_din = $urandom;
            s3_din = $urandom; s4_din = $urandom;
        end
        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
